// File: rtl/mem_wb_skid_pkg.sv
// mem_wb_skid_pkg: shared state encoding and constants for the mem/wb pipeline register.
package mem_wb_skid_pkg;
    typedef enum logic [1:0] {
        MEMWB_EMPTY = 2'd0,
        MEMWB_ONE   = 2'd1,
        MEMWB_TWO   = 2'd2
    } memwb_state_e;
    localparam logic WriteDisable = 1'b0;
endpackage

// File: rtl/mem_wb_skid_if.sv
// mem_wb_skid_if: valid/ready result channel carrying {wd, wreg, wdata}.
interface mem_wb_skid_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    modport master (output valid, wd, wreg, wdata, input ready);
    modport slave  (input valid, wd, wreg, wdata, output ready);
endinterface

// File: rtl/mem_wb_skid_wb_entry_reg.sv
// wb_entry_reg: one buffered write-back result with valid flag; clear beats load.
module wb_entry_reg
    import mem_wb_skid_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              ld_i,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o
);
    logic              valid_q;
    logic [ADDR_W-1:0] wd_q;
    logic              wreg_q;
    logic [DATA_W-1:0] wdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            valid_q <= 1'b0;
            wd_q    <= '0;
            wreg_q  <= WriteDisable;
            wdata_q <= '0;
        end else if (ld_i) begin
            valid_q <= 1'b1;
            wd_q    <= wd_i;
            wreg_q  <= wreg_i;
            wdata_q <= wdata_i;
        end
    end

    assign valid_o = valid_q;
    assign wd_o    = wd_q;
    assign wreg_o  = wreg_q;
    assign wdata_o = wdata_q;
endmodule

// File: rtl/mem_wb_skid.sv
// mem_wb_skid: mem->write-back pipeline register with main+skid buffer, flush and registered ready.
// Optional stall counter output enabled by MEMWB_STALL_CNT_EN.
module mem_wb_skid
    import mem_wb_skid_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    mem_wb_skid_if.slave          mem_i,
    mem_wb_skid_if.master         wb_o
`ifdef MEMWB_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt_o
`endif
);
    memwb_state_e      state_q, state_d;
    logic              ready_q;
    logic              accept, drain;
    logic              main_ld, main_clr, skid_ld, skid_clr;
    logic              m_valid, m_wreg, s_valid, s_wreg;
    logic [ADDR_W-1:0] m_wd, s_wd, m_wd_in;
    logic [DATA_W-1:0] m_wdata, s_wdata, m_wdata_in;
    logic              m_wreg_in;

    always_comb begin
        accept     = mem_i.valid && ready_q;
        drain      = m_valid && wb_o.ready;
        state_d    = flush_i                 ? MEMWB_EMPTY :
                     state_q == MEMWB_EMPTY  ? (accept ? MEMWB_ONE : MEMWB_EMPTY) :
                     state_q == MEMWB_ONE    ? (accept && !drain ? MEMWB_TWO :
                                                !accept && drain ? MEMWB_EMPTY : MEMWB_ONE) :
                     state_q == MEMWB_TWO    ? (drain ? MEMWB_ONE : MEMWB_TWO) : MEMWB_EMPTY;
        main_ld    = !flush_i && ((accept && (state_q == MEMWB_EMPTY || drain)) ||
                                  (state_q == MEMWB_TWO && drain));
        main_clr   = flush_i || (state_q == MEMWB_ONE && drain && !accept);
        skid_ld    = !flush_i && state_q == MEMWB_ONE && accept && !drain;
        skid_clr   = flush_i || (state_q == MEMWB_TWO && drain);
        // in TWO the main entry refills from skid, otherwise straight from mem
        m_wd_in    = state_q == MEMWB_TWO ? s_wd    : mem_i.wd;
        m_wreg_in  = state_q == MEMWB_TWO ? s_wreg  : mem_i.wreg;
        m_wdata_in = state_q == MEMWB_TWO ? s_wdata : mem_i.wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MEMWB_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= state_d != MEMWB_TWO;
        end
    end

    wb_entry_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (main_clr),
        .ld_i    (main_ld),
        .wd_i    (m_wd_in),
        .wreg_i  (m_wreg_in),
        .wdata_i (m_wdata_in),
        .valid_o (m_valid),
        .wd_o    (m_wd),
        .wreg_o  (m_wreg),
        .wdata_o (m_wdata)
    );

    wb_entry_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (skid_clr),
        .ld_i    (skid_ld),
        .wd_i    (mem_i.wd),
        .wreg_i  (mem_i.wreg),
        .wdata_i (mem_i.wdata),
        .valid_o (s_valid),
        .wd_o    (s_wd),
        .wreg_o  (s_wreg),
        .wdata_o (s_wdata)
    );

    assign mem_i.ready = ready_q && rst_n;
    assign wb_o.valid  = m_valid;
    assign wb_o.wd     = m_valid ? m_wd : '0;
    assign wb_o.wreg   = m_valid && m_wreg;
    assign wb_o.wdata  = m_valid ? m_wdata : '0;

`ifdef MEMWB_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_q <= '0;
        else if (m_valid && !wb_o.ready && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cnt_o = stall_q;
`endif
endmodule

// File: tb/tb_mem_wb_skid.sv
// tb_mem_wb_skid: vector table plus queue-scoreboard checks of mem_wb_skid.
module tb_mem_wb_skid;
    logic clk = 1'b0;
    logic rst_n, flush;
    int   n_cmp = 0, n_bad = 0;
    bit   started = 0;

    mem_wb_skid_if #(.ADDR_W(5), .DATA_W(64)) mi ();
    mem_wb_skid_if #(.ADDR_W(5), .DATA_W(64)) wi ();

`ifdef MEMWB_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] m_cnt;
`endif

    mem_wb_skid #(.ADDR_W(5), .DATA_W(64)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .mem_i   (mi),
        .wb_o    (wi)
`ifdef MEMWB_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [63:0] wdata;
    } res_t;
    res_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: FIFO of depth two, updated at each edge
    always @(posedge clk) begin
        logic dr, ac;
        if (!rst_n) begin
            q.delete();
            started = 1;
`ifdef MEMWB_STALL_CNT_EN
            m_cnt = 0;
`endif
        end else begin
`ifdef MEMWB_STALL_CNT_EN
            if (q.size() > 0 && !wi.ready && m_cnt != 32'hFFFF_FFFF) m_cnt++;
`endif
            dr = q.size() > 0 && wi.ready;
            ac = mi.valid && q.size() < 2;
            if (flush) q.delete();
            else begin
                if (dr) void'(q.pop_front());
                if (ac) q.push_back('{mi.wd, mi.wreg, mi.wdata});
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("sb_ready", mi.ready, rst_n && q.size() < 2);
            chk("sb_valid", wi.valid, q.size() > 0);
            chk("sb_wd", wi.wd, q.size() > 0 ? q[0].wd : 5'd0);
            chk("sb_wreg", wi.wreg, q.size() > 0 ? q[0].wreg : 1'b0);
            chk("sb_wdata", wi.wdata, q.size() > 0 ? q[0].wdata : 64'd0);
`ifdef MEMWB_STALL_CNT_EN
            chk("sb_cnt", stall_cnt, m_cnt);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] wd, input logic wr, input logic [63:0] d, input logic r);
        mi.valid = v; mi.wd = wd; mi.wreg = wr; mi.wdata = d; wi.ready = r;
    endtask

    typedef struct {
        logic        rst_n, flush, valid;
        logic [4:0]  wd;
        logic        wreg;
        logic [63:0] wdata;
        logic        rdy;
        logic        e_valid, e_ready;
        logic [4:0]  e_wd;
        logic        e_wreg;
        logic [63:0] e_wdata;
    } vec_t;
    vec_t vecs[8];

    initial begin
        vecs[0] = '{0, 0, 0, 5'd0, 0, 64'h0,         1, 0, 0, 5'd0, 0, 64'h0};
        vecs[1] = '{1, 0, 0, 5'd0, 0, 64'h0,         1, 0, 1, 5'd0, 0, 64'h0};
        vecs[2] = '{1, 0, 1, 5'd3, 1, 64'hDEAD_BEEF, 1, 1, 1, 5'd3, 1, 64'hDEAD_BEEF};
        vecs[3] = '{1, 0, 0, 5'd0, 0, 64'h0,         1, 0, 1, 5'd0, 0, 64'h0};
        vecs[4] = '{1, 0, 1, 5'd7, 0, 64'h5,         0, 1, 1, 5'd7, 0, 64'h5};
        vecs[5] = '{1, 0, 0, 5'd0, 0, 64'h0,         1, 0, 1, 5'd0, 0, 64'h0};
        vecs[6] = '{0, 0, 1, 5'd9, 1, 64'hAA,        1, 0, 0, 5'd0, 0, 64'h0};
        vecs[7] = '{1, 0, 0, 5'd0, 0, 64'h0,         1, 0, 1, 5'd0, 0, 64'h0};

        rst_n = 0; flush = 0;
        drive(0, 0, 0, 0, 1);
        tick(); tick();

        for (int i = 0; i < 8; i++) begin
            rst_n = vecs[i].rst_n; flush = vecs[i].flush;
            drive(vecs[i].valid, vecs[i].wd, vecs[i].wreg, vecs[i].wdata, vecs[i].rdy);
            tick();
            chk("vec_valid", wi.valid, vecs[i].e_valid);
            chk("vec_ready", mi.ready, vecs[i].e_ready);
            chk("vec_wd", wi.wd, vecs[i].e_wd);
            chk("vec_wreg", wi.wreg, vecs[i].e_wreg);
            chk("vec_wdata", wi.wdata, vecs[i].e_wdata);
        end

        // back-to-back streaming
        for (int k = 1; k <= 8; k++) begin
            drive(1, 5'(k), 1, 64'(k), 1);
            tick();
            chk("stream_ready", mi.ready, 1'b1);
            chk("stream_data", wi.wdata, 64'(k));
        end
        drive(0, 0, 0, 0, 1);
        tick();
        chk("stream_end", wi.valid, 1'b0);

        // stall fill, then release in order
        drive(1, 5'd1, 1, 64'h11, 0); tick();
        chk("fill_a_ready", mi.ready, 1'b1);
        drive(1, 5'd2, 1, 64'h22, 0); tick();
        chk("fill_b_ready", mi.ready, 1'b0);
        chk("fill_b_hold", wi.wdata, 64'h11);
        drive(1, 5'd3, 1, 64'h33, 0); tick();
        chk("fill_c_hold", wi.wdata, 64'h11);
        chk("fill_c_ready", mi.ready, 1'b0);
        drive(0, 0, 0, 0, 1); tick();
        chk("drain_b", wi.wdata, 64'h22);
        chk("drain_b_ready", mi.ready, 1'b1);
        drive(1, 5'd3, 1, 64'h33, 1); tick();
        chk("drain_c", wi.wdata, 64'h33);
        drive(0, 0, 0, 0, 1); tick();
        chk("drain_empty", wi.valid, 1'b0);

        // flush collides with an accept attempt in TWO
        drive(1, 5'd4, 1, 64'h44, 0); tick();
        drive(1, 5'd5, 1, 64'h55, 0); tick();
        chk("flush_pre_ready", mi.ready, 1'b0);
        flush = 1;
        drive(1, 5'd9, 1, 64'h99, 0); tick();
        flush = 0;
        chk("flush_valid", wi.valid, 1'b0);
        chk("flush_ready", mi.ready, 1'b1);
        drive(0, 0, 0, 0, 1);
        repeat (3) begin
            tick();
            chk("flush_no99", wi.wdata, 64'h0);
        end

`ifdef MEMWB_STALL_CNT_EN
        rst_n = 0; tick(); rst_n = 1;
        drive(1, 5'd6, 1, 64'h66, 0); tick();
        drive(0, 0, 0, 0, 0);
        repeat (10) tick();
        chk("cnt_ten", stall_cnt, 32'd10);
        flush = 1; wi.ready = 1; tick(); flush = 0;
        chk("cnt_after_flush", stall_cnt, 32'd10);
        rst_n = 0; tick(); rst_n = 1;
        chk("cnt_after_reset", stall_cnt, 32'd0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
